wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus architectural register file, directly downstream of the MEM/WB pipeline register.
//  Selects the write-back value (load data, ALU result or JAL link address) and commits it to a 2^ADDR_W x DATA_W register file.
//  Provides two combinational read ports to the ID stage, with write-to-read bypass, and a committed-write counter for debug and performance.
// PARAMETERS
//  DATA_W    32  register / data width
//  ADDR_W    5   register index width (2^ADDR_W registers)
//  LINK_REG  31  destination index forced by jal
//  BYPASS    1   1 = a read of the register being written this cycle returns the new value; 0 = returns the old value
// PORTS
//  Clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  memtoreg_in  in   1       1 = write back read_data_in, 0 = write back alures_in
//  regwrite_in  in   1       register write request
//  jal_in       in   1       jal: write add_res_in to LINK_REG (overrides regwrite_in and memtoreg_in)
//  wreg_in      in   ADDR_W  destination register (used when jal_in=0)
//  read_data_in in   DATA_W  load data from MEM/WB
//  alures_in    in   DATA_W  ALU result from MEM/WB
//  add_res_in   in   DATA_W  link address (PC+4/PC+8) from MEM/WB
//  rs_addr      in   ADDR_W  read port A index (ID stage)
//  rt_addr      in   ADDR_W  read port B index (ID stage)
//  rs_data      out  DATA_W  read port A data, combinational
//  rt_data      out  DATA_W  read port B data, combinational
//  wb_data      out  DATA_W  selected write-back value, combinational (for EX forwarding)
//  wb_dest      out  ADDR_W  effective destination index, combinational
//  wb_we        out  1       effective write enable, combinational
//  commit_cnt   out  32      count of committed writes, registered
// BEHAVIOUR
//  - Data select: wb_data = jal_in ? add_res_in : (memtoreg_in ? read_data_in : alures_in).
//  - Destination select: wb_dest = jal_in ? LINK_REG : wreg_in.
//  - Write enable: wb_we = (regwrite_in | jal_in) & (wb_dest != 0) & ~reset.
//  - Commit: on posedge Clk with wb_we=1, regs[wb_dest] <= wb_data. Latency is 1 edge; the value is visible architecturally on the next cycle.
//  - Register 0 is hard-wired to zero: writes are dropped, reads return 0 (including via the bypass path). Storage for reg 0 is optional.
//  - Reads: rs_data = (rs_addr==0) ? 0 : (BYPASS & wb_we & rs_addr==wb_dest) ? wb_data : regs[rs_addr]. rt_data follows the same rule.
//  - The bypass applies to both ports at once: rs_addr==rt_addr==wb_dest returns wb_data on both.
//  - commit_cnt increments by 1 on each edge where wb_we=1 and wraps from 2^32-1 to 0.
//  - Reset (sync): on posedge Clk with reset=1, every register and commit_cnt clear to 0, and no write commits even if regwrite_in/jal_in are set.
//  - Reset outputs:
//    - rs_data, rt_data and wb_we read 0 during reset and on the first cycle after.
//    - wb_data and wb_dest still reflect the inputs.
//  - Reset mid-stream: a write presented on the same edge as reset is lost. Upstream stages are reset by the same signal.
//  - X-safety: when wb_we=0, do not decode wreg_in/data. No latches; every output is fully defined for all input combinations.
// TESTING
//  1. Reset: assert reset 1 cycle with regwrite_in=1, wreg_in=5 -> after release rs_addr=5 gives rs_data=0 and commit_cnt=0.
//  2. ALU/load select:
//     - regwrite=1, memtoreg=0, wreg=3, alures=0x1234 -> next cycle rt_addr=3 gives 0x1234.
//     - Then memtoreg=1, read_data=0xDEADBEEF to reg 3 -> reads 0xDEADBEEF.
//     - commit_cnt=2.
//  3. JAL: jal_in=1, regwrite_in=0, wreg_in=7, add_res_in=0x00400008 -> reg31=0x00400008, reg7 unchanged, wb_dest=31.
//  4. Zero register: regwrite=1, wreg=0, alures=0xFFFFFFFF -> rs_addr=0 gives 0 in the same cycle and after, wb_we=0, commit_cnt unchanged.
//  5. Bypass:
//     - Same cycle as a write of 0xA5A5A5A5 to reg 9, rs_addr=rt_addr=9 -> both ports give 0xA5A5A5A5 with BYPASS=1.
//     - With BYPASS=0 both give the old value.
//  6. Counter wrap: preload commit_cnt=0xFFFFFFFF (force), commit one write -> commit_cnt=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back bus between the MEM/WB pipeline register / ID stage and the register file.
// The master drives the write-back request and read indices; the slave returns read data and commit status.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              memtoreg_in;
    logic              regwrite_in;
    logic              jal_in;
    logic [ADDR_W-1:0] wreg_in;
    logic [DATA_W-1:0] read_data_in;
    logic [DATA_W-1:0] alures_in;
    logic [DATA_W-1:0] add_res_in;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_we;
    logic [31:0]       commit_cnt;

    modport master (
        output memtoreg_in, regwrite_in, jal_in, wreg_in,
        output read_data_in, alures_in, add_res_in, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_dest, wb_we, commit_cnt
    );

    modport slave (
        input  memtoreg_in, regwrite_in, jal_in, wreg_in,
        input  read_data_in, alures_in, add_res_in, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_dest, wb_we, commit_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back value, commits it,
// serves two combinational read ports with optional write-to-read bypass, and counts commits.
module wb_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input logic          Clk,
    input logic          reset,
    wb_regfile_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [31:0]       r_commit_cnt;

    logic [DATA_W-1:0] w_wb_data;
    logic [ADDR_W-1:0] w_wb_dest;
    logic              w_wb_we;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Write-back selection; jal overrides both the data mux and the destination.
    always_comb begin
        w_wb_data = bus.alures_in;
        w_wb_dest = bus.wreg_in;
        if (bus.jal_in) begin
            w_wb_data = bus.add_res_in;
            w_wb_dest = ADDR_W'(LINK_REG);
        end else if (bus.memtoreg_in) begin
            w_wb_data = bus.read_data_in;
        end
        w_wb_we = (bus.regwrite_in | bus.jal_in) & (w_wb_dest != '0) & ~reset;
    end

    // Read ports: reg 0 and reset force zero, then bypass, then storage.
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (!reset && (bus.rs_addr != '0)) begin
            if (BYPASS && w_wb_we && (bus.rs_addr == w_wb_dest)) w_rs_data = w_wb_data;
            else                                                 w_rs_data = r_regs[bus.rs_addr];
        end
        if (!reset && (bus.rt_addr != '0)) begin
            if (BYPASS && w_wb_we && (bus.rt_addr == w_wb_dest)) w_rt_data = w_wb_data;
            else                                                 w_rt_data = r_regs[bus.rt_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
            r_commit_cnt <= '0;
        end else if (w_wb_we) begin
            r_regs[w_wb_dest] <= w_wb_data;
            r_commit_cnt      <= r_commit_cnt + 32'd1;
        end
    end

    assign bus.wb_data    = w_wb_data;
    assign bus.wb_dest    = w_wb_dest;
    assign bus.wb_we      = w_wb_we;
    assign bus.rs_data    = w_rs_data;
    assign bus.rt_data    = w_rt_data;
    assign bus.commit_cnt = r_commit_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two instances (bypass on/off) driven in lockstep from a vector table,
// expectations queued at drive time and checked before the committing edge.
module tb_wb_regfile;
    logic Clk;
    logic reset;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b1)) dut1 (
        .Clk(Clk), .reset(reset), .bus(bus1.slave));
    wb_regfile #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b0)) dut0 (
        .Clk(Clk), .reset(reset), .bus(bus0.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, rw, m, j;
        logic [4:0]  wreg;
        logic [31:0] rd, alu, add;
        logic [4:0]  rs, rt;
        logic [31:0] e_rs, e_rt, e_rs0, e_rt0, e_wbd;
        logic [4:0]  e_dest;
        logic        e_we;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    vec_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset             = v.rst;
        bus1.regwrite_in  = v.rw;   bus0.regwrite_in  = v.rw;
        bus1.memtoreg_in  = v.m;    bus0.memtoreg_in  = v.m;
        bus1.jal_in       = v.j;    bus0.jal_in       = v.j;
        bus1.wreg_in      = v.wreg; bus0.wreg_in      = v.wreg;
        bus1.read_data_in = v.rd;   bus0.read_data_in = v.rd;
        bus1.alures_in    = v.alu;  bus0.alures_in    = v.alu;
        bus1.add_res_in   = v.add;  bus0.add_res_in   = v.add;
        bus1.rs_addr      = v.rs;   bus0.rs_addr      = v.rs;
        bus1.rt_addr      = v.rt;   bus0.rt_addr      = v.rt;
    endtask

    task automatic check_vec(input int idx, input vec_t e);
        chk($sformatf("v%0d rs_data", idx),       bus1.rs_data,    e.e_rs);
        chk($sformatf("v%0d rt_data", idx),       bus1.rt_data,    e.e_rt);
        chk($sformatf("v%0d rs_data_nobyp", idx), bus0.rs_data,    e.e_rs0);
        chk($sformatf("v%0d rt_data_nobyp", idx), bus0.rt_data,    e.e_rt0);
        chk($sformatf("v%0d wb_data", idx),       bus1.wb_data,    e.e_wbd);
        chk($sformatf("v%0d wb_dest", idx),       32'(bus1.wb_dest), 32'(e.e_dest));
        chk($sformatf("v%0d wb_we", idx),         32'(bus1.wb_we),   32'(e.e_we));
        chk($sformatf("v%0d commit_cnt", idx),    bus1.commit_cnt, e.e_cnt);
        chk($sformatf("v%0d commit_cnt_nobyp", idx), bus0.commit_cnt, e.e_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        vec_t e;
        //          rst rw m  j  wreg rd            alu           add           rs  rt  e_rs          e_rt          e_rs0         e_rt0         e_wbd         dest we cnt
        tbl[0]  = '{1, 1, 0, 0, 5,  32'h0,        32'h55,       32'h0,        5,  5,  32'h0,        32'h0,        32'h0,        32'h0,        32'h55,       5,  0, 0};
        tbl[1]  = '{0, 0, 0, 0, 5,  32'h0,        32'h55,       32'h0,        5,  0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h55,       5,  0, 0};
        tbl[2]  = '{0, 1, 0, 0, 3,  32'h0,        32'h1234,     32'h0,        0,  3,  32'h0,        32'h1234,     32'h0,        32'h0,        32'h1234,     3,  1, 0};
        tbl[3]  = '{0, 1, 1, 0, 3,  32'hDEADBEEF, 32'h1234,     32'h0,        3,  3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h1234,     32'h1234,     32'hDEADBEEF, 3,  1, 1};
        tbl[4]  = '{0, 0, 0, 0, 3,  32'hDEADBEEF, 32'h1234,     32'h0,        3,  3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1234,     3,  0, 2};
        tbl[5]  = '{0, 0, 1, 1, 7,  32'hDEADBEEF, 32'h1234,     32'h00400008, 31, 7,  32'h00400008, 32'h0,        32'h0,        32'h0,        32'h00400008, 31, 1, 2};
        tbl[6]  = '{0, 0, 0, 0, 7,  32'h0,        32'h1234,     32'h0,        31, 7,  32'h00400008, 32'h0,        32'h00400008, 32'h0,        32'h1234,     7,  0, 3};
        tbl[7]  = '{0, 1, 0, 0, 0,  32'h0,        32'hFFFFFFFF, 32'h0,        0,  3,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 0,  0, 3};
        tbl[8]  = '{0, 0, 0, 0, 0,  32'h0,        32'hFFFFFFFF, 32'h0,        0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 0,  0, 3};
        tbl[9]  = '{0, 1, 0, 0, 9,  32'h0,        32'h11111111, 32'h0,        9,  0,  32'h11111111, 32'h0,        32'h0,        32'h0,        32'h11111111, 9,  1, 3};
        tbl[10] = '{0, 1, 0, 0, 9,  32'h0,        32'hA5A5A5A5, 32'h0,        9,  9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111, 32'hA5A5A5A5, 9,  1, 4};
        tbl[11] = '{0, 0, 0, 0, 9,  32'h0,        32'hA5A5A5A5, 32'h0,        9,  9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 9,  0, 5};
        tbl[12] = '{0, 1, 0, 1, 0,  32'h0,        32'h0,        32'h00400010, 31, 0,  32'h00400010, 32'h0,        32'h00400008, 32'h0,        32'h00400010, 31, 1, 5};
        tbl[13] = '{0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        31, 9,  32'h00400010, 32'hA5A5A5A5, 32'h00400010, 32'hA5A5A5A5, 32'h0,        0,  0, 6};
        tbl[14] = '{1, 1, 0, 0, 12, 32'h0,        32'hCAFE,     32'h0,        12, 9,  32'h0,        32'h0,        32'h0,        32'h0,        32'hCAFE,     12, 0, 6};
        tbl[15] = '{0, 0, 0, 0, 12, 32'h0,        32'h0,        32'h0,        12, 9,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        12, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 12, 32'h0,        32'h0,        32'h0,        31, 3,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        12, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 12, 32'h0,        32'h0,        32'h0,        31, 12, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        12, 0, 0};

        idle = tbl[17];
        drive(idle);
        reset = 1'b1;
        repeat (3) @(posedge Clk);

        // Table: drive on the falling edge, check just before the committing rising edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            drive(tbl[i]);
            sb_q.push_back(tbl[i]);
            #3;
            e = sb_q.pop_front();
            check_vec(i, e);
        end

        // Counter wrap: preload both counters to all-ones, then commit one write.
        @(negedge Clk);
        drive(idle);
        force dut1.r_commit_cnt = 32'hFFFFFFFF;
        force dut0.r_commit_cnt = 32'hFFFFFFFF;
        @(negedge Clk);
        release dut1.r_commit_cnt;
        release dut0.r_commit_cnt;
        idle.rw = 1'b1; idle.wreg = 5'd4; idle.alu = 32'h7; idle.rs = 5'd4;
        drive(idle);
        #3;
        chk("wrap pre we", 32'(bus1.wb_we), 32'd1);
        chk("wrap pre rs bypass", bus1.rs_data, 32'h7);
        chk("wrap pre rs nobyp", bus0.rs_data, 32'h0);
        @(negedge Clk);
        idle.rw = 1'b0;
        drive(idle);
        #3;
        chk("wrap commit_cnt", bus1.commit_cnt, 32'h0);
        chk("wrap commit_cnt nobyp", bus0.commit_cnt, 32'h0);
        chk("wrap reg4", bus1.rs_data, 32'h7);
        chk("wrap reg4 nobyp", bus0.rs_data, 32'h7);

        // Two back-to-back writes then one more: counter walks 0 -> 1 -> 2.
        @(negedge Clk);
        idle.rw = 1'b1; idle.wreg = 5'd20; idle.alu = 32'h0BADF00D; idle.rs = 5'd20; idle.rt = 5'd20;
        drive(idle);
        #3;
        chk("b2b first rt bypass", bus1.rt_data, 32'h0BADF00D);
        @(negedge Clk);
        idle.alu = 32'h600DCAFE;
        drive(idle);
        #3;
        chk("b2b second rs bypass", bus1.rs_data, 32'h600DCAFE);
        chk("b2b second rs nobyp", bus0.rs_data, 32'h0BADF00D);
        chk("b2b cnt mid", bus1.commit_cnt, 32'd1);
        @(negedge Clk);
        idle.rw = 1'b0;
        drive(idle);
        #3;
        chk("b2b final reg20", bus0.rt_data, 32'h600DCAFE);
        chk("b2b cnt end", bus1.commit_cnt, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
